// File: rtl/bp_me_dma_mem_bridge.sv
// L2-bank DMA to in-order memory port bridge: splits block transactions into fill-width beat commands.
// Optional BP_ME_DMA_BRIDGE_SKIP_MASKED_EN: zero-mask write beats are consumed without a memory command.
module bp_me_dma_mem_bridge #(
    parameter int unsigned daddr_width_p         = 32,
    parameter int unsigned word_width_p          = 64,
    parameter int unsigned block_size_in_words_p = 8,
    parameter int unsigned fill_width_p          = 128,
    parameter int unsigned credits_p             = 4
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [block_size_in_words_p+daddr_width_p:0]  dma_pkt_i,
    input  logic                                          dma_pkt_v_i,
    output logic                                          dma_pkt_ready_and_o,
    input  logic [fill_width_p-1:0]                       dma_data_i,
    input  logic                                          dma_data_v_i,
    output logic                                          dma_data_ready_and_o,
    output logic [fill_width_p-1:0]                       dma_data_o,
    output logic                                          dma_data_v_o,
    input  logic                                          dma_data_ready_and_i,
    output logic [daddr_width_p-1:0]                      mem_cmd_addr_o,
    output logic                                          mem_cmd_w_o,
    output logic [fill_width_p-1:0]                       mem_cmd_data_o,
    output logic [fill_width_p/8-1:0]                     mem_cmd_mask_o,
    output logic                                          mem_cmd_v_o,
    input  logic                                          mem_cmd_ready_and_i,
    input  logic [fill_width_p-1:0]                       mem_resp_data_i,
    input  logic                                          mem_resp_v_i,
    output logic                                          mem_resp_ready_and_o
);

    localparam int unsigned Beats      = block_size_in_words_p * word_width_p / fill_width_p;
    localparam int unsigned Wpb        = fill_width_p / word_width_p;
    localparam int unsigned WordBytes  = word_width_p / 8;
    localparam int unsigned FillBytes  = fill_width_p / 8;
    localparam int unsigned BlockBytes = block_size_in_words_p * word_width_p / 8;
    localparam int unsigned MaskW      = fill_width_p / 8;
    localparam int unsigned PktW       = 1 + block_size_in_words_p + daddr_width_p;
    localparam int unsigned BeatW      = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned CntW       = $clog2(credits_p + 1);
    localparam int unsigned PtrW       = (credits_p > 1) ? $clog2(credits_p) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_e;

    state_e                             state_q;
    logic [BeatW-1:0]                   beat_q;
    logic [CntW-1:0]                    outstanding_q;
    logic [daddr_width_p-1:0]           base_q;
    logic [block_size_in_words_p-1:0]   mask_q;
    logic [fill_width_p-1:0]            fifo_q [credits_p];
    logic [PtrW-1:0]                    rptr_q, wptr_q;
    logic [CntW-1:0]                    count_q;

    logic                               pkt_w;
    logic [block_size_in_words_p-1:0]   pkt_mask;
    logic [daddr_width_p-1:0]           pkt_addr;
    logic [Wpb-1:0]                     word_mask;
    logic [MaskW-1:0]                   byte_mask;
    logic                               last_beat;
    logic                               pkt_fire, rd_fire, wr_fire, resp_fire, drain_fire;

    assign pkt_w     = dma_pkt_i[PktW-1];
    assign pkt_mask  = dma_pkt_i[PktW-2 -: block_size_in_words_p];
    assign pkt_addr  = dma_pkt_i[daddr_width_p-1:0];
    assign last_beat = (beat_q == BeatW'(Beats - 1));

    // Expand the latched per-word mask of the current beat into a byte mask.
    always_comb begin
        word_mask = mask_q[beat_q*Wpb +: Wpb];
        for (int b = 0; b < MaskW; b++) begin
            byte_mask[b] = word_mask[b / WordBytes];
        end
    end

    always_comb begin
        dma_pkt_ready_and_o  = 1'b0;
        dma_data_ready_and_o = 1'b0;
        mem_cmd_v_o          = 1'b0;
        mem_cmd_w_o          = 1'b0;
        mem_cmd_mask_o       = '0;
        mem_cmd_data_o       = dma_data_i;
        mem_cmd_addr_o       = base_q + daddr_width_p'(beat_q) * daddr_width_p'(FillBytes);
        case (state_q)
            S_IDLE: dma_pkt_ready_and_o = (outstanding_q == '0) || !pkt_w;
            S_RD:   mem_cmd_v_o = (outstanding_q < CntW'(credits_p));
            S_WR: begin
                mem_cmd_w_o    = 1'b1;
                mem_cmd_mask_o = byte_mask;
`ifdef BP_ME_DMA_BRIDGE_SKIP_MASKED_EN
                mem_cmd_v_o          = dma_data_v_i && (byte_mask != '0);
                dma_data_ready_and_o = mem_cmd_ready_and_i || (byte_mask == '0);
`else
                mem_cmd_v_o          = dma_data_v_i;
                dma_data_ready_and_o = mem_cmd_ready_and_i;
`endif
            end
            default: ;
        endcase
        if (!reset_n_i) begin
            dma_pkt_ready_and_o  = 1'b0;
            dma_data_ready_and_o = 1'b0;
            mem_cmd_v_o          = 1'b0;
        end
    end

    assign mem_resp_ready_and_o = reset_n_i && (count_q != CntW'(credits_p));
    assign dma_data_v_o         = reset_n_i && (count_q != '0);
    assign dma_data_o           = fifo_q[rptr_q];

    assign pkt_fire   = dma_pkt_v_i && dma_pkt_ready_and_o;
    assign rd_fire    = (state_q == S_RD) && mem_cmd_v_o && mem_cmd_ready_and_i;
    assign wr_fire    = (state_q == S_WR) && dma_data_v_i && dma_data_ready_and_o;
    assign resp_fire  = mem_resp_v_i && mem_resp_ready_and_o;
    assign drain_fire = dma_data_v_o && dma_data_ready_and_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            outstanding_q <= '0;
            base_q        <= '0;
            mask_q        <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (pkt_fire) begin
                    base_q  <= pkt_addr & ~daddr_width_p'(BlockBytes - 1);
                    mask_q  <= pkt_mask;
                    beat_q  <= '0;
                    state_q <= pkt_w ? S_WR : S_RD;
                end
                S_RD: if (rd_fire) begin
                    beat_q <= beat_q + BeatW'(1);
                    if (last_beat) state_q <= S_IDLE;
                end
                S_WR: if (wr_fire) begin
                    beat_q <= beat_q + BeatW'(1);
                    if (last_beat) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // Issue and drain in the same cycle cancel out.
            outstanding_q <= outstanding_q + CntW'(rd_fire) - CntW'(drain_fire);
            if (resp_fire)  wptr_q <= (wptr_q == PtrW'(credits_p - 1)) ? '0 : wptr_q + PtrW'(1);
            if (drain_fire) rptr_q <= (rptr_q == PtrW'(credits_p - 1)) ? '0 : rptr_q + PtrW'(1);
            count_q <= count_q + CntW'(resp_fire) - CntW'(drain_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (resp_fire) fifo_q[wptr_q] <= mem_resp_data_i;
    end

endmodule
